// File: rtl/rtc_pkg.sv
// -----------------------------------------------------------------------------
// rtc_pkg
// Shared constants and helpers for the real-time-clock timekeeper.
//   - Field widths for seconds / minutes / hours / day.
//   - Terminal values of each cascade stage, typed to their field width so
//     comparisons against the counters need no extension.
//   - set_is_legal(): range check applied to a requested hh:mm load.
// -----------------------------------------------------------------------------
package rtc_pkg;

    localparam int SEC_W  = 6;
    localparam int MIN_W  = 6;
    localparam int HOUR_W = 5;
    localparam int DAY_W  = 3;

    localparam logic [SEC_W-1:0]  SEC_MAX  = 6'd59;
    localparam logic [MIN_W-1:0]  MIN_MAX  = 6'd59;
    localparam logic [HOUR_W-1:0] HOUR_MAX = 5'd23;
    localparam logic [DAY_W-1:0]  DAY_MAX  = 3'd6;

    // A load is only accepted when both fields are inside their 24-hour range.
    function automatic logic set_is_legal(input logic [HOUR_W-1:0] hours,
                                          input logic [MIN_W-1:0]  minutes);
        return (hours <= HOUR_MAX) && (minutes <= MIN_MAX);
    endfunction

endpackage

// File: rtl/rtc_prescaler.sv
// -----------------------------------------------------------------------------
// rtc_prescaler
// Divides the system clock into a one-second tick.  The counter runs
// 0..CLK_HZ-1 while run=1 and holds its value while run=0, so a paused second
// resumes where it stopped.  A synchronous clear restarts the second.
//
// Parameters
//   CLK_HZ  system clock cycles per second (>= 2)
// Ports
//   clock   system clock, rising edge
//   resetn  asynchronous active-low reset
//   run     1 = count, 0 = hold
//   clear   synchronous restart of the count (wins over run)
//   tick    high during the cycle the counter sits at terminal count with
//           run=1; consumed by registered logic in the parent
// -----------------------------------------------------------------------------
module rtc_prescaler
    import rtc_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic clock,
    input  logic resetn,
    input  logic run,
    input  logic clear,
    output logic tick
);

    localparam int               CNT_W    = $clog2(CLK_HZ);
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLK_HZ - 1);

    logic [CNT_W-1:0] count;

    assign tick = run && (count == TERMINAL);

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values, independent of process evaluation order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear || tick) begin
            count <= '0;
        end else if (run) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/rtc_timekeeper.sv
// -----------------------------------------------------------------------------
// rtc_timekeeper
// 24-hour hh:mm:ss time-of-day source.  A prescaler produces one tick per
// second; the top cascades seconds -> minutes -> hours and handles the set
// handshake.  Every output is a flop: time fields and pulses change on the
// same edge, so a consumer sampling on secondP=1 sees the new time.
//
// A legal set wins over a coincident tick (the tick is dropped and the
// prescaler restarts).  An illegal set leaves time alone and lets a coincident
// tick through.
//
// Optional build macro: RTC_DAY_EN adds a day-of-week counter (day, dayP).
//
// Parameters
//   CLK_HZ       system clock cycles per second (>= 2)
// Ports
//   clock        system clock, rising edge
//   resetn       asynchronous active-low reset
//   run          1 = time advances, 0 = prescaler and counters frozen
//   set_valid    load request, evaluated every cycle it is high
//   set_hours    requested hours   (0..23 legal)
//   set_minutes  requested minutes (0..59 legal)
//   secondP      one-cycle pulse with each new second
//   seconds      current seconds 0..59
//   minutes      current minutes 0..59
//   hours        current hours   0..23
//   minuteP      one-cycle pulse when seconds wraps to 0
//   day, dayP    (RTC_DAY_EN only) day 0..6 and its wrap pulse
//   set_ack      one-cycle pulse, load accepted
//   set_err      one-cycle pulse, load rejected
// -----------------------------------------------------------------------------
module rtc_timekeeper
    import rtc_pkg::*;
#(
    parameter int CLK_HZ = 50000000
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              run,
    input  logic              set_valid,
    input  logic [HOUR_W-1:0] set_hours,
    input  logic [MIN_W-1:0]  set_minutes,
    output logic              secondP,
    output logic [SEC_W-1:0]  seconds,
    output logic [MIN_W-1:0]  minutes,
    output logic [HOUR_W-1:0] hours,
    output logic              minuteP,
`ifdef RTC_DAY_EN
    output logic [DAY_W-1:0]  day,
    output logic              dayP,
`endif
    output logic              set_ack,
    output logic              set_err
);

    logic set_legal;
    logic set_ok;
    logic set_bad;
    logic tick;
    logic tick_take;
    logic sec_wrap;
    logic min_wrap;
    logic hour_wrap;

    assign set_legal = set_is_legal(set_hours, set_minutes);
    assign set_ok    = set_valid && set_legal;
    assign set_bad   = set_valid && !set_legal;
    // A legal load discards a tick arriving in the same cycle.
    assign tick_take = tick && !set_ok;

    assign sec_wrap  = (seconds == SEC_MAX);
    assign min_wrap  = (minutes == MIN_MAX);
    assign hour_wrap = (hours   == HOUR_MAX);

    rtc_prescaler #(
        .CLK_HZ (CLK_HZ)
    ) u_prescaler (
        .clock  (clock),
        .resetn (resetn),
        .run    (run),
        .clear  (set_ok),
        .tick   (tick)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            seconds <= '0;
            minutes <= '0;
            hours   <= '0;
            secondP <= 1'b0;
            minuteP <= 1'b0;
            set_ack <= 1'b0;
            set_err <= 1'b0;
        end else begin
            secondP <= tick_take;
            minuteP <= tick_take && sec_wrap;
            set_ack <= set_ok;
            set_err <= set_bad;

            if (set_ok) begin
                hours   <= set_hours;
                minutes <= set_minutes;
                seconds <= '0;
            end else if (tick_take) begin
                if (sec_wrap) begin
                    seconds <= '0;
                    if (min_wrap) begin
                        minutes <= '0;
                        hours   <= hour_wrap ? '0 : hours + 1'b1;
                    end else begin
                        minutes <= minutes + 1'b1;
                    end
                end else begin
                    seconds <= seconds + 1'b1;
                end
            end
        end
    end

`ifdef RTC_DAY_EN
    logic day_wrap;

    assign day_wrap = tick_take && sec_wrap && min_wrap && hour_wrap;

    // Day of week follows only the midnight roll-over; a set never touches it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            day  <= '0;
            dayP <= 1'b0;
        end else begin
            dayP <= day_wrap;
            if (day_wrap) begin
                day <= (day == DAY_MAX) ? '0 : day + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rtc_timekeeper.sv
// -----------------------------------------------------------------------------
// tb_rtc_timekeeper
// Self-checking bench for rtc_timekeeper with CLK_HZ=10.  The reference model
// keeps time as a count of seconds since midnight plus a cycle phase within
// the current second; hh:mm:ss are derived with division.  Each driven cycle
// that should produce a pulse pushes an expected record (edge number, pulses,
// time) into a queue; an independent monitor pops and compares whenever the
// DUT shows secondP, set_ack or set_err.  Works with or without RTC_DAY_EN.
// -----------------------------------------------------------------------------
module tb_rtc_timekeeper;
    import rtc_pkg::*;

    localparam int CLK_HZ   = 10;
    localparam int DAY_SECS = 24 * 3600;

    logic              clock = 1'b0;
    logic              resetn = 1'b0;
    logic              run = 1'b0;
    logic              set_valid = 1'b0;
    logic [HOUR_W-1:0] set_hours = '0;
    logic [MIN_W-1:0]  set_minutes = '0;
    logic              secondP;
    logic [SEC_W-1:0]  seconds;
    logic [MIN_W-1:0]  minutes;
    logic [HOUR_W-1:0] hours;
    logic              minuteP;
    logic              set_ack;
    logic              set_err;
`ifdef RTC_DAY_EN
    logic [DAY_W-1:0]  day;
    logic              dayP;
`endif

    rtc_timekeeper #(
        .CLK_HZ      (CLK_HZ)
    ) dut (
        .clock       (clock),
        .resetn      (resetn),
        .run         (run),
        .set_valid   (set_valid),
        .set_hours   (set_hours),
        .set_minutes (set_minutes),
        .secondP     (secondP),
        .seconds     (seconds),
        .minutes     (minutes),
        .hours       (hours),
        .minuteP     (minuteP),
`ifdef RTC_DAY_EN
        .day         (day),
        .dayP        (dayP),
`endif
        .set_ack     (set_ack),
        .set_err     (set_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        int edge_no;
        bit sp;
        bit mp;
        bit dp;
        bit ack;
        bit err;
        int h;
        int m;
        int s;
        int d;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   now_edge = 0;

    // Reference model state.
    int m_tod   = 0;
    int m_phase = 0;
    int m_day   = 0;

    always @(posedge clock) now_edge <= now_edge + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Drive one cycle's inputs and advance the model across the coming edge.
    task automatic step(input bit r, input bit sv, input int h, input int m);
        exp_t e;
        bit   legal;
        @(negedge clock);
        run         = r;
        set_valid   = sv;
        set_hours   = HOUR_W'(h);
        set_minutes = MIN_W'(m);
        legal = sv && (h <= 23) && (m <= 59);
        e = '{default: 0};
        e.edge_no = now_edge + 1;
        e.ack     = legal;
        e.err     = sv && !legal;
        if (legal) begin
            m_tod   = h * 3600 + m * 60;
            m_phase = 0;
        end else if (r) begin
            if (m_phase == CLK_HZ - 1) begin
                m_phase = 0;
                m_tod   = (m_tod + 1) % DAY_SECS;
                e.sp    = 1'b1;
                e.mp    = (m_tod % 60) == 0;
                if (m_tod == 0) begin
                    m_day = (m_day + 1) % 7;
                    e.dp  = 1'b1;
                end
            end else begin
                m_phase++;
            end
        end
        e.h = m_tod / 3600;
        e.m = (m_tod / 60) % 60;
        e.s = m_tod % 60;
        e.d = m_day;
        if (e.sp || e.ack || e.err) sb_q.push_back(e);
    endtask

    // Let the edge belonging to the last step happen, then sample.
    task automatic settle();
        @(posedge clock);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_secondP"}, secondP, 0);
        check({tag, "_minuteP"}, minuteP, 0);
        check({tag, "_set_ack"}, set_ack, 0);
        check({tag, "_set_err"}, set_err, 0);
        check({tag, "_time"}, {hours, minutes, seconds}, 0);
`ifdef RTC_DAY_EN
        check({tag, "_day"}, {day, dayP}, 0);
`endif
    endtask

    // Release lands 1 ns before a falling edge so the next step drives the
    // very first edge after release.
    task automatic release_reset();
        @(posedge clock);
        #4 resetn = 1'b1;
    endtask

    task automatic async_reset();
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        check_all_zero("async_reset");
        run       = 1'b0;
        set_valid = 1'b0;
        m_tod     = 0;
        m_phase   = 0;
        m_day     = 0;
        @(posedge clock);
        release_reset();
    endtask

    // Monitor: compare every presented pulse cycle against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (resetn && (secondP || set_ack || set_err)) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_pulse: got secondP=%b ack=%b err=%b at edge %0d, expected no pulse",
                             secondP, set_ack, set_err, now_edge);
                end else begin
                    e = sb_q.pop_front();
                    check("edge_no", now_edge, e.edge_no);
                    check("secondP", secondP, e.sp);
                    check("minuteP", minuteP, e.mp);
                    check("set_ack", set_ack, e.ack);
                    check("set_err", set_err, e.err);
                    check("hours", hours, e.h);
                    check("minutes", minutes, e.m);
                    check("seconds", seconds, e.s);
`ifdef RTC_DAY_EN
                    check("day", day, e.d);
                    check("dayP", dayP, e.dp);
`endif
                end
            end
            while (sb_q.size() > 0 && sb_q[0].edge_no <= now_edge) begin
                e = sb_q.pop_front();
                checks++;
                failures++;
                $display("FAIL missed_pulse: got no pulse at edge %0d, expected sp=%b ack=%b err=%b",
                         e.edge_no, e.sp, e.ack, e.err);
            end
        end
    end

    initial begin
        // Reset state.
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_all_zero("reset");
        release_reset();

        // Free-running from reset: ticks on edges 10, 20, 30.
        repeat (35) step(1, 0, 0, 0);
        settle();
        check("sec_after_35", seconds, 3);

        // 23:59 then 60 seconds -> midnight roll-over.
        step(1, 1, 23, 59);
        repeat (600) step(1, 0, 0, 0);
        settle();
        check("wrap_time", {hours, minutes, seconds}, 0);
        check("wrap_minuteP", minuteP, 1);
`ifdef RTC_DAY_EN
        check("wrap_day", day, 1);
        check("wrap_dayP", dayP, 1);
`endif

        // Illegal loads, then a legal one.
        step(1, 1, 24, 0);
        step(1, 1, 8, 60);
        step(1, 1, 8, 0);
        settle();
        check("set8_ack", set_ack, 1);
        check("set8_time", {hours, minutes, seconds}, {5'd8, 6'd0, 6'd0});

        // Legal set exactly at terminal count: tick dropped.
        for (int i = 0; i < CLK_HZ && m_phase != CLK_HZ - 1; i++) step(1, 0, 0, 0);
        step(1, 1, 10, 20);
        repeat (9) step(1, 0, 0, 0);
        settle();
        check("tc_set_no_early_tick", secondP, 0);
        step(1, 0, 0, 0);
        settle();
        check("tc_set_tick_after_10", secondP, 1);

        // Pause at count 4 for 7 cycles; resume finishes the second in 6.
        for (int i = 0; i < CLK_HZ && m_phase != 4; i++) step(1, 0, 0, 0);
        repeat (7) step(0, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0);
        settle();
        check("resume_not_yet", secondP, 0);
        step(1, 0, 0, 0);
        settle();
        check("resume_tick_6", secondP, 1);

        // 12:34:56 mid-second, then asynchronous reset.
        step(1, 1, 12, 34);
        repeat (56 * CLK_HZ + 5) step(1, 0, 0, 0);
        settle();
        check("pre_reset_time", {hours, minutes, seconds}, {5'd12, 6'd34, 6'd56});
        async_reset();
        repeat (CLK_HZ) step(1, 0, 0, 0);
        settle();
        check("post_reset_tick", secondP, 1);
        check("post_reset_sec", seconds, 1);

        // Randomised traffic.
        for (int i = 0; i < 2000; i++) begin
            step(($urandom_range(0, 9) != 0),
                 ($urandom_range(0, 29) == 0),
                 $urandom_range(0, 31),
                 $urandom_range(0, 63));
        end

        // Drain and confirm nothing expected is left outstanding.
        repeat (3) step(0, 0, 0, 0);
        settle();
        @(negedge clock);
        #1;
        check("scoreboard_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
